// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Purpose : Shared definitions for the data-side bus responder.
//           - funct3 access-size codes
//           - FSM state encodings
//           - latched-request record
//           - helpers for error decode and load-data extension
// Ports   : none (package)
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  // Access-size codes carried on bus_funct3 (RV32I load/store funct3).
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // One accepted request, including its precomputed error decode.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        err;
  } req_t;

  // Any true term flags the access as an error.
  // The window test uses wrapping subtraction, so addresses below the
  // base turn into huge offsets and fall out of the window as well.
  function automatic logic access_err(
    input logic [31:0] addr,
    input logic [2:0]  f3,
    input logic        we,
    input logic [31:0] base,
    input int unsigned aw
  );
    logic [31:0] off;
    logic        out_of_window;
    logic        misaligned;
    logic        bad_size;
    logic        bad_store;
    off           = addr - base;
    out_of_window = (off >> (aw + 2)) != 32'd0;
    misaligned    = (((f3 == SIZE_H) || (f3 == SIZE_HU)) && addr[0]) ||
                    ((f3 == SIZE_W) && (addr[1:0] != 2'b00));
    bad_size      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    bad_store     = we && ((f3 == SIZE_BU) || (f3 == SIZE_HU));
    return out_of_window || misaligned || bad_size || bad_store;
  endfunction

  // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [2:0]  f3
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (f3)
      SIZE_B:  res = {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  res = {{16{sh[15]}}, sh[15:0]};
      SIZE_BU: res = {24'd0, sh[7:0]};
      SIZE_HU: res = {16'd0, sh[15:0]};
      SIZE_W:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Purpose : Core data-bus load/store handshake between an initiator (core)
//           and a target (data_mem_responder).
// Signals : bus_req    initiator -> target  request valid, held until ready
//           bus_we     initiator -> target  1 = store, 0 = load
//           bus_addr   initiator -> target  byte address
//           bus_wdata  initiator -> target  right-aligned store data
//           bus_funct3 initiator -> target  access size
//           bus_rdata  target -> initiator  extended load data (0 unless ready)
//           bus_ready  target -> initiator  one-cycle response pulse
//           bus_err    target -> initiator  error, qualified by bus_ready
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_funct3;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_funct3,
    input  bus_rdata, bus_ready, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_funct3,
    output bus_rdata, bus_ready, bus_err
  );
endinterface

// File: rtl/data_mem_responder_ram_be_array.sv
// -----------------------------------------------------------------------------
// ram_be_array
// Purpose : 2**ADDR_WIDTH x 32 synchronous RAM with per-byte write enables
//           and a registered read (read-before-write on the same address).
// Ports   : clk    in   clock, rising edge
//           we     in   write strobe
//           be     in   4  byte-lane enables, lane n = wdata[8n+7:8n]
//           widx   in   ADDR_WIDTH word index (shared by read and write)
//           wdata  in   32 write data, already steered onto its lanes
//           rdata  out  32 word read at the previous edge
// Contents are never reset.
// -----------------------------------------------------------------------------
module ram_be_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] widx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // One byte-wide array per lane keeps each lane a plain inferred RAM.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          r_mem[widx] <= wdata[8*gi +: 8];
        end
        r_q <= r_mem[widx];
      end

      assign rdata[8*gi +: 8] = r_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Purpose : Data-side bus target for the RV32I core. Decodes an address
//           window over a word-organised RAM, performs B/H/W stores with
//           byte enables, returns sign/zero-extended loads after
//           WAIT_CYCLES wait states, and flags misaligned, out-of-window
//           and illegal-size accesses.
// Ports   : clk    in  clock, rising edge
//           reset  in  asynchronous, active-high
//           bus    data_mem_responder_if.slave (req/we/addr/wdata/funct3 in,
//                  rdata/ready/err out)
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  req_t                  r_req;

  logic                  w_live_err;
  req_t                  w_live;
  req_t                  w_cur;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic [ADDR_WIDTH-1:0] w_widx;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_ram_we;
  logic [31:0]           w_ram_rdata;
  logic                  w_ready;

  assign w_live_err = access_err(bus.bus_addr, bus.bus_funct3, bus.bus_we,
                                 BASE_ADDR, ADDR_WIDTH);

  always_comb begin
    w_live = '{we:     bus.bus_we,
               addr:   bus.bus_addr,
               wdata:  bus.bus_wdata,
               funct3: bus.bus_funct3,
               err:    w_live_err};
  end

  // In IDLE the RAM is driven straight from the bus so that a zero-wait
  // request can read/write on the same edge that accepts it; otherwise the
  // latched request drives it.
  assign w_cur = (r_state == ST_IDLE) ? w_live : r_req;

  assign w_accept     = (r_state == ST_IDLE) && bus.bus_req;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd1));

  // Word index of the offset inside the window; truncation drops the
  // byte bits and everything above the RAM depth.
  assign w_widx = ADDR_WIDTH'((w_cur.addr - BASE_ADDR) >> 2);

  // Replicate right-aligned store data onto every lane; be selects which
  // lanes actually land.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = w_cur.wdata;
    case (w_cur.funct3)
      SIZE_B: begin
        w_be    = 4'b0001 << w_cur.addr[1:0];
        w_wdata = {4{w_cur.wdata[7:0]}};
      end
      SIZE_H: begin
        w_be    = w_cur.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_cur.wdata[15:0]}};
      end
      SIZE_W: begin
        w_be    = 4'b1111;
      end
      default: begin
        w_be    = 4'b0000;
      end
    endcase
  end

  assign w_ram_we = w_enter_resp && w_cur.we && !w_cur.err;

  ram_be_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .be    (w_be),
    .widx  (w_widx),
    .wdata (w_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.bus_req) begin
            r_req <= w_live;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= LP_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the state so they are zero outside the
  // response cycle, including straight out of reset.
  assign w_ready       = (r_state == ST_RESP);
  assign bus.bus_ready = w_ready;
  assign bus.bus_err   = w_ready && r_req.err;
  assign bus.bus_rdata = (w_ready && !r_req.we && !r_req.err)
                         ? load_extend(w_ram_rdata, r_req.addr[1:0], r_req.funct3)
                         : 32'd0;

endmodule
